// File: rtl/swi_input_conditioner.sv
// Switch input conditioner: two-flop synchroniser, per-bit debounce,
// registered rise/fall pulses, and a single-step pulse with a wrapping step counter.
module swi_input_conditioner #(
  parameter int unsigned NBITS_TOP       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STEP_BIT        = 0
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic [NBITS_TOP-1:0] SWI,
  output logic [NBITS_TOP-1:0] swi_stable,
  output logic [NBITS_TOP-1:0] swi_rise,
  output logic [NBITS_TOP-1:0] swi_fall,
  output logic                 swi_changed,
  output logic                 step_pulse,
  output logic [7:0]           step_count
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NBITS_TOP-1:0] sync1_q, sync2_q;
  logic [NBITS_TOP-1:0] stable_q, stable_d;
  logic [NBITS_TOP-1:0] rise_q, rise_d;
  logic [NBITS_TOP-1:0] fall_q, fall_d;
  logic [CNT_W-1:0]     cnt_q [NBITS_TOP];
  logic [CNT_W-1:0]     cnt_d [NBITS_TOP];
  logic [7:0]           step_cnt_q, step_cnt_d;

  // A change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int unsigned i = 0; i < NBITS_TOP; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          rise_d[i]   = sync2_q[i];
          fall_d[i]   = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    step_cnt_d = rise_d[STEP_BIT] ? step_cnt_q + 8'd1 : step_cnt_q;
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      cnt_q      <= '{default: '0};
      step_cnt_q <= '0;
    end else begin
      sync1_q    <= SWI;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      cnt_q      <= cnt_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign swi_stable  = stable_q;
  assign swi_rise    = rise_q;
  assign swi_fall    = fall_q;
  assign swi_changed = |(rise_q | fall_q);
  assign step_pulse  = rise_q[STEP_BIT];
  assign step_count  = step_cnt_q;

endmodule

// File: tb/tb_swi_input_conditioner.sv
// Self-checking bench for swi_input_conditioner: a sample-history model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_swi_input_conditioner;

  localparam int unsigned NB  = 8;
  localparam int unsigned DB  = 4;
  localparam int unsigned STB = 0;

  logic          clk_2 = 1'b0;
  logic          reset;
  logic [NB-1:0] SWI;
  logic [NB-1:0] swi_stable, swi_rise, swi_fall;
  logic          swi_changed, step_pulse;
  logic [7:0]    step_count;

  int checks   = 0;
  int failures = 0;

  swi_input_conditioner #(
    .NBITS_TOP      (NB),
    .DEBOUNCE_CYCLES(DB),
    .STEP_BIT       (STB)
  ) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .SWI        (SWI),
    .swi_stable (swi_stable),
    .swi_rise   (swi_rise),
    .swi_fall   (swi_fall),
    .swi_changed(swi_changed),
    .step_pulse (step_pulse),
    .step_count (step_count)
  );

  always #5 clk_2 = ~clk_2;

  // Model: the sample seen by the debouncer at an edge is the SWI value captured
  // two edges earlier; a level is accepted once DB consecutive samples disagree with it.
  logic [NB-1:0] hist [$];
  logic [NB-1:0] m_stable, m_rise, m_fall;
  logic [7:0]    m_steps;
  int            m_run [NB];
  bit            m_valid = 1'b0;

  always @(posedge clk_2) begin
    logic [NB-1:0] seen;
    m_rise = '0;
    m_fall = '0;
    if (reset) begin
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      m_stable = '0;
      m_steps  = 8'd0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      seen = hist[hist.size() - 2];
      for (int i = 0; i < NB; i++) begin
        if (seen[i] != m_stable[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= DB) begin
            m_stable[i] = seen[i];
            if (seen[i]) m_rise[i] = 1'b1;
            else         m_fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (m_rise[STB]) m_steps = m_steps + 8'd1;
      hist.push_back(SWI);
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_2) begin
    if (m_valid) begin
      chk("model_stable", 32'(swi_stable), 32'(m_stable));
      chk("model_rise", 32'(swi_rise), 32'(m_rise));
      chk("model_fall", 32'(swi_fall), 32'(m_fall));
      chk("model_changed", 32'(swi_changed), 32'(|(m_rise | m_fall)));
      chk("model_step_pulse", 32'(step_pulse), 32'(m_rise[STB]));
      chk("model_step_count", 32'(step_count), 32'(m_steps));
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  initial begin
    reset = 1'b1;
    SWI   = '0;
    wait_n(2);
    chk("reset_stable", 32'(swi_stable), 32'h0);
    chk("reset_step_count", 32'(step_count), 32'h0);
    reset = 1'b0;

    // 1: idle input keeps everything quiet
    wait_n(20);
    chk("idle_stable", 32'(swi_stable), 32'h0);
    chk("idle_changed", 32'(swi_changed), 32'h0);

    // 2: single step, accepted on the sixth edge
    SWI = 8'h01;
    wait_n(5);
    chk("step_early_stable", 32'(swi_stable), 32'h00);
    wait_n(1);
    chk("step_stable", 32'(swi_stable), 32'h01);
    chk("step_rise", 32'(swi_rise), 32'h01);
    chk("step_pulse", 32'(step_pulse), 32'h1);
    chk("step_changed", 32'(swi_changed), 32'h1);
    chk("step_count1", 32'(step_count), 32'h01);
    wait_n(1);
    chk("step_rise_gone", 32'(swi_rise), 32'h00);
    chk("step_pulse_gone", 32'(step_pulse), 32'h0);

    // 3: three-cycle glitch on bit 3 is discarded
    SWI = 8'h09;
    wait_n(3);
    SWI = 8'h01;
    wait_n(12);
    chk("glitch_stable", 32'(swi_stable), 32'h01);

    // 4: return to zero, then two bits together, then drop bit 0
    SWI = 8'h00;
    wait_n(12);
    chk("zero_stable", 32'(swi_stable), 32'h00);
    SWI = 8'h81;
    wait_n(6);
    chk("pair_rise", 32'(swi_rise), 32'h81);
    chk("pair_count", 32'(step_count), 32'h02);
    wait_n(4);
    SWI = 8'h80;
    wait_n(6);
    chk("drop_fall", 32'(swi_fall), 32'h01);
    chk("drop_rise", 32'(swi_rise), 32'h00);
    chk("drop_count", 32'(step_count), 32'h02);
    wait_n(1);
    chk("drop_fall_gone", 32'(swi_fall), 32'h00);

    // 5: 256 step presses from a fresh reset wrap the counter
    SWI = '0;
    reset = 1'b1;
    wait_n(1);
    reset = 1'b0;
    for (int n = 0; n < 256; n++) begin
      SWI = 8'h01;
      wait_n(10);
      SWI = 8'h00;
      wait_n(10);
    end
    chk("wrap_count0", 32'(step_count), 32'h00);
    SWI = 8'h01;
    wait_n(10);
    chk("wrap_count1", 32'(step_count), 32'h01);
    SWI = 8'h00;
    wait_n(10);

    // 6: reset mid-debounce aborts, then the held level is re-detected
    SWI = 8'h04;
    wait_n(3);
    reset = 1'b1;
    wait_n(1);
    chk("abort_stable", 32'(swi_stable), 32'h00);
    chk("abort_count", 32'(step_count), 32'h00);
    reset = 1'b0;
    wait_n(5);
    chk("rearm_early", 32'(swi_rise), 32'h00);
    wait_n(1);
    chk("rearm_rise", 32'(swi_rise), 32'h04);
    chk("rearm_stable", 32'(swi_stable), 32'h04);
    wait_n(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
